// File: rtl/keccak_pkg.sv
// Shared definitions for the SHA-3 absorb/permute sequencing path:
// state encoding and Keccak geometry constants.
package keccak_pkg;

    localparam int KECCAK_NROUNDS = 24;
    localparam int KECCAK_NCHUNKS = 8;
    localparam int KECCAK_RND_W   = 5;
    localparam int CHUNK_W        = 200;
    localparam int LANE_W         = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PERMUTE,
        DONE
    } ksc_state_t;

endpackage

// File: rtl/keccak_round_cnt.sv
// Keccak round counter: steps while start is high, returns to zero on clear,
// and flags the final round so the owner can stop the permutation.
module keccak_round_cnt
    import keccak_pkg::*;
#(
    parameter int NROUNDS = KECCAK_NROUNDS,
    parameter int RND_W   = KECCAK_RND_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    output logic [RND_W-1:0] round_idx,
    output logic             last
);

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NROUNDS - 1);

    // Clear takes priority so the counter never runs past the last round.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            round_idx <= '0;
        end else if (start) begin
            round_idx <= round_idx + RND_W'(1);
        end
    end

    assign last = (round_idx == LAST_ROUND);

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Absorb/permute sequencer: loads eight ordered chunks, runs the round schedule,
// then hands the result downstream. Optional macro KSC_PERF_CNT_EN adds perm_count.
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int NROUNDS = KECCAK_NROUNDS,
    parameter int NCHUNKS = KECCAK_NCHUNKS,
    parameter int RND_W   = KECCAK_RND_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushin,
    input  logic [2:0]       dix,
    output logic             stopin,
    output logic             load_we,
    output logic [2:0]       load_dix,
    output logic             round_en,
    output logic [RND_W-1:0] round_idx,
    output logic             pushout,
    input  logic             stopout,
    output logic             err_seq,
    output logic [31:0]      perm_count
);

    localparam logic [2:0] LAST_DIX = 3'(NCHUNKS - 1);

    ksc_state_t state, state_next;
    logic [2:0] exp_cnt, exp_cnt_next;
    logic       accept;
    logic       err_next;
    logic       transfer;
    logic       round_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            exp_cnt <= '0;
            err_seq <= 1'b0;
        end else begin
            state   <= state_next;
            exp_cnt <= exp_cnt_next;
            err_seq <= err_next;
        end
    end

    // stopin depends only on the registered state, so upstream sees no input-to-output path.
    always_comb begin
        state_next   = state;
        exp_cnt_next = exp_cnt;
        stopin       = (state == PERMUTE) || (state == DONE);
        accept       = pushin && !stopin && (dix == exp_cnt);
        load_we      = accept;
        load_dix     = accept ? dix : 3'd0;
        err_next     = pushin && !accept;
        round_en     = (state == PERMUTE);
        pushout      = (state == DONE);
        transfer     = pushout && !stopout;

        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (dix == LAST_DIX) begin
                        exp_cnt_next = 3'd0;
                        state_next   = PERMUTE;
                    end else begin
                        exp_cnt_next = exp_cnt + 3'd1;
                        state_next   = LOAD;
                    end
                end
            end
            PERMUTE: begin
                if (round_last) state_next = DONE;
            end
            DONE: begin
                if (transfer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    keccak_round_cnt #(
        .NROUNDS (NROUNDS),
        .RND_W   (RND_W)
    ) u_round_cnt (
        .clk       (clk),
        .reset     (reset),
        .start     (round_en && !round_last),
        .clear     (round_en && round_last),
        .round_idx (round_idx),
        .last      (round_last)
    );

`ifdef KSC_PERF_CNT_EN
    logic [31:0] perm_count_r;

    // Counts handed-off results; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_count_r <= '0;
        end else if (transfer) begin
            perm_count_r <= perm_count_r + 32'd1;
        end
    end

    assign perm_count = perm_count_r;
`else
    assign perm_count = 32'd0;
`endif

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Self-checking bench for keccak_sponge_ctrl: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the sponge sequence.
module tb_keccak_sponge_ctrl;

    localparam int NCH = 8;
    localparam int NRD = 24;

    logic        clk;
    logic        reset;
    logic        pushin;
    logic [2:0]  dix;
    logic        stopin;
    logic        load_we;
    logic [2:0]  load_dix;
    logic        round_en;
    logic [4:0]  round_idx;
    logic        pushout;
    logic        stopout;
    logic        err_seq;
    logic [31:0] perm_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    // Model: chunks gathered so far, current round (-1 when not permuting),
    // a result waiting for downstream, a pending error pulse, finished blocks.
    int          m_loaded;
    int          m_round;
    bit          m_hold;
    bit          m_err;
    logic [31:0] m_perm;

    logic        r_p;
    logic [2:0]  r_d;
    logic        r_s;
    logic        r_r;

    keccak_sponge_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pushin     (pushin),
        .dix        (dix),
        .stopin     (stopin),
        .load_we    (load_we),
        .load_dix   (load_dix),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .pushout    (pushout),
        .stopout    (stopout),
        .err_seq    (err_seq),
        .perm_count (perm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_loaded = 0;
        m_round  = -1;
        m_hold   = 1'b0;
        m_err    = 1'b0;
        m_perm   = 32'd0;
    endtask

    // Compare every output at the falling edge, then advance the model across the rising edge.
    task automatic checkOutput();
        bit          busy;
        bit          acc;
        logic [31:0] exp_perm;
        busy = (m_round >= 0) || m_hold;
        acc  = pushin && !busy && (int'(dix) == m_loaded);
`ifdef KSC_PERF_CNT_EN
        exp_perm = m_perm;
`else
        exp_perm = 32'd0;
`endif
        @(negedge clk);
        cmp("stopin",     32'(stopin),    32'(busy));
        cmp("load_we",    32'(load_we),   32'(acc));
        cmp("load_dix",   32'(load_dix),  acc ? 32'(dix) : 32'd0);
        cmp("round_en",   32'(round_en),  32'(m_round >= 0));
        cmp("round_idx",  32'(round_idx), (m_round >= 0) ? 32'(m_round) : 32'd0);
        cmp("pushout",    32'(pushout),   32'(m_hold));
        cmp("err_seq",    32'(err_seq),   32'(m_err));
        cmp("perm_count", perm_count,     exp_perm);
        @(posedge clk);
        cycle++;
        if (reset) begin
            modelReset();
        end else begin
            m_err = pushin && !acc;
            if (acc) begin
                if (m_loaded == NCH - 1) begin
                    m_loaded = 0;
                    m_round  = 0;
                end else begin
                    m_loaded++;
                end
            end else if (m_round >= 0) begin
                if (m_round == NRD - 1) begin
                    m_round = -1;
                    m_hold  = 1'b1;
                end else begin
                    m_round++;
                end
            end else if (m_hold && !stopout) begin
                m_hold = 1'b0;
                m_perm = m_perm + 32'd1;
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input logic p, input logic [2:0] d, input logic so, input logic rst);
        pushin  = p;
        dix     = d;
        stopout = so;
        reset   = rst;
        checkOutput();
    endtask

    task automatic loadAll();
        for (int k = 0; k < NCH; k++) applyStimulus(1'b1, 3'(k), 1'b0, 1'b0);
    endtask

    task automatic runUntilRound(input int r);
        for (int k = 0; k < 64 && m_round != r; k++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic runBlock(input int stall);
        loadAll();
        for (int k = 0; k < NRD; k++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < stall; k++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        pushin  = 1'b0;
        dix     = 3'd0;
        stopout = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        $display("[TB] reset state");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] in-order block");
        runBlock(0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] out-of-order chunk");
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
        for (int k = 1; k < NCH; k++) applyStimulus(1'b1, 3'(k), 1'b0, 1'b0);
        for (int k = 0; k < NRD + 2; k++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] downstream stall");
        runBlock(10);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] push during permute");
        loadAll();
        runUntilRound(5);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < NRD; k++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] reset mid-permute");
        loadAll();
        runUntilRound(12);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        runBlock(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            r_p = ($urandom_range(0, 3) != 0);
            r_d = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'(m_loaded);
            r_s = ($urandom_range(0, 2) == 0);
            r_r = ($urandom_range(0, 299) == 0);
            applyStimulus(r_p, r_d, r_s, r_r);
        end

        $display("[TB] completed-hash counter");
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) runBlock($urandom_range(0, 4));
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
`ifdef KSC_PERF_CNT_EN
        cmp("perm_count_3", perm_count, 32'd3);
        force dut.perm_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.perm_count_r;
        m_perm = 32'hFFFF_FFFF;
        runBlock(1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("perm_count_wrap", perm_count, 32'd0);
`else
        cmp("perm_count_off", perm_count, 32'd0);
        runBlock(1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        cmp("perm_count_off2", perm_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Sequencing controller for the SHA-3 absorb/permute path. It accepts eight 200-bit input chunks (dix 0..7) through a push/stop handshake and drives the write strobes of the input interface that fills the 5x5x64 Keccak state. Once the 1600-bit state is complete, it runs the 24-round permutation by issuing round enables and round indices. It then presents the result downstream with a push/stop handshake and returns to idle.

Parameters:
NROUNDS, 24, permutation rounds per block
NCHUNKS, 8, input chunks per 1600-bit state (dix range 0..NCHUNKS-1)
RND_W, 5, round index width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pushin  input  1  upstream chunk valid
dix  input  3  upstream chunk index
stopin  output  1  upstream backpressure; chunk not accepted while high
load_we  output  1  write strobe to input interface (accepted chunk)
load_dix  output  3  chunk index to input interface, valid with load_we
round_en  output  1  permutation core advances one round this cycle
round_idx  output  RND_W  current round number, valid with round_en
pushout  output  1  result valid downstream
stopout  input  1  downstream backpressure
err_seq  output  1  one-cycle pulse: out-of-order or dropped chunk
perm_count  output  32  completed-hash counter (see Optional Feature)

Behaviour:
- Single clock domain. Synchronous active-high reset; all state is updated only on posedge clk.
- States:
  - IDLE: expect dix 0
  - LOAD: expect dix = exp_cnt
  - PERMUTE
  - DONE
- Reset values:
  - state=IDLE, exp_cnt=0, round counter=0
  - stopin=0, load_we=0, load_dix=0, round_en=0, round_idx=0, pushout=0, err_seq=0, perm_count=0
- stopin = 1 in PERMUTE and DONE, 0 in IDLE and LOAD. Decoded from the registered state only; no combinational path from any input.
- Accept condition: pushin & ~stopin & (dix == exp_cnt).
- On accept:
  - load_we and load_dix are combinational from pushin/dix in the same cycle (zero latency), matching the input interface's register-on-clock behaviour.
  - exp_cnt increments.
  - IDLE moves to LOAD.
- Out-of-order chunk (pushin & ~stopin & dix != exp_cnt):
  - load_we=0; chunk dropped.
  - err_seq pulses for one cycle, registered (asserted the cycle after).
  - exp_cnt unchanged.
- pushin while stopin=1: ignored; err_seq pulses next cycle.
- Accept of dix = NCHUNKS-1: exp_cnt wraps to 0; the next state is PERMUTE.
- PERMUTE:
  - round_en=1 every cycle.
  - round_idx is registered, 0 on entry, incrementing by 1 per cycle.
  - Latency is exactly NROUNDS cycles: round_idx 0..NROUNDS-1.
  - After round_idx = NROUNDS-1, the next state is DONE and the round counter clears to 0.
- DONE:
  - pushout=1, held until a cycle with pushout & ~stopout.
  - That transfer cycle moves to IDLE; pushout=0 on the next cycle.
  - stopout held high keeps DONE indefinitely; no timeout.
- Back-to-back operation: first acceptance of a new dix 0 is possible the cycle after returning to IDLE. Minimum block period is NCHUNKS + NROUNDS + 1 cycles.
- Reset mid-operation (any state): next cycle returns to IDLE with all reset values. Partial chunks are abandoned; perm_count clears.
- round_idx wraps only through the explicit clear; no free-running overflow.

Optional Feature:
- Macro: KSC_PERF_CNT_EN.
- Defined: perm_count is a 32-bit register that increments on each DONE-to-IDLE transfer and wraps from 0xFFFFFFFF to 0. Reset clears it.
- Not defined: perm_count is tied to 0 and no counter flops are synthesized. The port list is identical in both builds.

Decomposition:
- Shared package keccak_pkg holds:
  - state encoding typedef (IDLE/LOAD/PERMUTE/DONE)
  - constants: KECCAK_NROUNDS=24, KECCAK_NCHUNKS=8, CHUNK_W=200, LANE_W=64
- One natural sub-module: keccak_round_cnt. It is the round counter with start/clear inputs and last-round flag output, reusable by the permutation core.
- FSM and handshake logic stay in the top module.

Test Plan:
- In-order load: push dix 0..7 on 8 consecutive cycles with stopout=0.
  - Expect load_we on all 8 cycles.
  - Expect stopin=1 from cycle 9, round_en for 24 cycles with round_idx 0..23.
  - Expect pushout for 1 cycle, then IDLE.
- Out-of-order: push dix 0, then dix 2.
  - Expect load_we=0 for the dix 2 cycle and err_seq pulse next cycle.
  - Push dix 1..7: the block completes normally.
- Downstream stall: hold stopout=1 for 10 cycles in DONE.
  - Expect pushout held for 10 cycles and stopin=1 throughout.
  - Release: transfer completes, IDLE next cycle.
- Push during PERMUTE: pushin=1, dix=0 at round_idx=5.
  - Expect no load_we, err_seq pulse, round sequence uninterrupted.
- Reset mid-operation: assert reset at round_idx=12.
  - Next cycle: all outputs at reset values.
  - A fresh load of dix 0..7 completes normally.
- KSC_PERF_CNT_EN build: run 3 blocks and expect perm_count=3. Preload 0xFFFFFFFF via force and run 1 block: expect 0. Non-macro build: perm_count stays 0.
